// File: rtl/pwm_ramp_pkg.sv
// Shared types and reset constants for the PWM duty-ramp sequencer.
// No logic; no latency; no backpressure.
package pwm_ramp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RAMP = 2'd2
    } state_t;

    localparam int MIN_PERIOD = 2;
    localparam int RST_PERIOD = MIN_PERIOD;
    localparam int RST_DUTY   = 0;

endpackage

// File: rtl/pwm_period_tick.sv
// Mirror of the PWM period counter; flags the last cycle of each period.
// Latency: period_tick is combinational from the counter; no backpressure.
module pwm_period_tick #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic [WIDTH-1:0] period,
    output logic             period_tick
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    assign period_tick = (cnt_q == period - WIDTH'(1));

    always_comb begin
        cnt_d = cnt_q + WIDTH'(1);
        if (period_tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Steps PWM duty toward a commanded target on period boundaries; optional irq via PWM_RAMP_IRQ_EN.
// Latency: period update within one old period of accept; done one cycle after final duty write.
// Backpressure: cmd_ready only in IDLE without abort; commands are never queued.
module pwm_ramp_ctrl
    import pwm_ramp_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int IVL_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [WIDTH-1:0]     cmd_period,
    input  logic [WIDTH-1:0]     cmd_target,
    input  logic [WIDTH-1:0]     cmd_step,
    input  logic [IVL_WIDTH-1:0] cmd_interval,
    input  logic                 abort,
    output logic [WIDTH-1:0]     period,
    output logic [WIDTH-1:0]     duty,
    output logic                 period_tick,
    output logic                 busy,
`ifdef PWM_RAMP_IRQ_EN
    output logic                 irq,
    input  logic                 irq_clr,
`endif
    output logic                 done
);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     period_q, period_d;
    logic [WIDTH-1:0]     duty_q, duty_d;
    logic [WIDTH-1:0]     lat_period_q, lat_period_d;
    logic [WIDTH-1:0]     target_q, target_d;
    logic [WIDTH-1:0]     step_q, step_d;
    logic [IVL_WIDTH-1:0] interval_q, interval_d;
    logic [IVL_WIDTH-1:0] ivl_cnt_q, ivl_cnt_d;
    logic                 done_q, done_d;
    logic                 cmd_acc;
    logic                 step_due;
    logic [WIDTH-1:0]     duty_next;

    pwm_period_tick #(.WIDTH(WIDTH)) u_tick (
        .clk         (clk),
        .nreset      (nreset),
        .period      (period_q),
        .period_tick (period_tick)
    );

    assign cmd_ready = (state_q == IDLE) && !abort;
    assign cmd_acc   = cmd_valid && cmd_ready;
    assign step_due  = (interval_q <= IVL_WIDTH'(1)) || (ivl_cnt_q == interval_q - IVL_WIDTH'(1));

    // Distance is compared against step before the add/sub so duty never overshoots or wraps.
    always_comb begin
        duty_next = target_q;
        if (step_q != '0) begin
            if (duty_q < target_q) begin
                if (target_q - duty_q > step_q) begin
                    duty_next = duty_q + step_q;
                end
            end else if (duty_q - target_q > step_q) begin
                duty_next = duty_q - step_q;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        period_d     = period_q;
        duty_d       = duty_q;
        lat_period_d = lat_period_q;
        target_d     = target_q;
        step_d       = step_q;
        interval_d   = interval_q;
        ivl_cnt_d    = ivl_cnt_q;
        done_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_acc) begin
                    lat_period_d = (cmd_period < WIDTH'(MIN_PERIOD)) ? WIDTH'(MIN_PERIOD) : cmd_period;
                    target_d     = cmd_target;
                    step_d       = cmd_step;
                    interval_d   = cmd_interval;
                    state_d      = SYNC;
                end
            end
            SYNC: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (period_tick) begin
                    period_d  = lat_period_q;
                    ivl_cnt_d = '0;
                    state_d   = RAMP;
                end
            end
            RAMP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (duty_q == target_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (period_tick) begin
                    if (step_due) begin
                        ivl_cnt_d = '0;
                        duty_d    = duty_next;
                    end else begin
                        ivl_cnt_d = ivl_cnt_q + IVL_WIDTH'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q      <= IDLE;
            period_q     <= WIDTH'(RST_PERIOD);
            duty_q       <= WIDTH'(RST_DUTY);
            lat_period_q <= WIDTH'(RST_PERIOD);
            target_q     <= '0;
            step_q       <= '0;
            interval_q   <= '0;
            ivl_cnt_q    <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_q     <= period_d;
            duty_q       <= duty_d;
            lat_period_q <= lat_period_d;
            target_q     <= target_d;
            step_q       <= step_d;
            interval_q   <= interval_d;
            ivl_cnt_q    <= ivl_cnt_d;
            done_q       <= done_d;
        end
    end

    assign period = period_q;
    assign duty   = duty_q;
    assign busy   = (state_q != IDLE);
    assign done   = done_q;

`ifdef PWM_RAMP_IRQ_EN
    logic irq_q, irq_d;

    // A new event in the same cycle as a clear keeps the flag set.
    always_comb begin
        irq_d = irq_q;
        if (irq_clr) begin
            irq_d = 1'b0;
        end
        if (done_d || (abort && busy)) begin
            irq_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

endmodule
